// File: rtl/calib_sched.sv
// calib_sched: round-robin front end that shares one wind-speed calibration
// engine between NCH sample requesters and tags each result with its channel.
module calib_sched #(
    parameter int NCH     = 4,
    parameter int DW      = 16,
    parameter int CAL_LAT = 5,
    parameter int CW      = $clog2(NCH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NCH-1:0]    req,
    input  logic [NCH*DW-1:0] din,
    output logic [NCH-1:0]    ack,
    output logic              cal_clear,
    output logic              cal_enable,
    output logic [DW-1:0]     cal_in,
    input  logic [DW-1:0]     cal_out,
    output logic [DW-1:0]     dout,
    output logic [CW-1:0]     dout_ch,
    output logic              dout_valid,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE,
        CLEAR,
        ISSUE,
        WAIT
    } state_t;

    localparam int LW = (CAL_LAT > 1) ? $clog2(CAL_LAT) : 1;

    state_t          state, state_n;
    logic [CW-1:0]   last_grant, last_n;
    logic [LW-1:0]   cnt, cnt_n;
    logic [NCH-1:0]  ack_n;
    logic            clr_n, en_n, dv_n, busy_n;
    logic [DW-1:0]   cal_in_n, dout_n;
    logic [CW-1:0]   ch_n;

    logic            win;
    logic [CW-1:0]   gnt;
    logic [DW-1:0]   sel;
    logic            arb;
    int              s;

    // Rotating priority: search begins just after the last winner.
    always_comb begin
        win = 1'b0;
        gnt = '0;
        sel = '0;
        s   = 0;
        for (int k = 1; k <= NCH; k++) begin
            s = int'(last_grant) + k;
            if (s >= NCH) begin
                s = s - NCH;
            end
            if (!win && req[CW'(s)]) begin
                win = 1'b1;
                gnt = CW'(s);
            end
        end
        for (int i = 0; i < NCH; i++) begin
            if (gnt == CW'(i)) begin
                sel = din[i*DW +: DW];
            end
        end
    end

    always_comb begin
        state_n  = state;
        last_n   = last_grant;
        cnt_n    = cnt;
        ack_n    = '0;
        clr_n    = 1'b0;
        en_n     = 1'b0;
        dv_n     = 1'b0;
        busy_n   = busy;
        cal_in_n = cal_in;
        dout_n   = dout;
        ch_n     = dout_ch;
        arb      = 1'b0;

        unique case (state)
            IDLE: begin
                arb = 1'b1;
            end
            CLEAR: begin
                en_n    = 1'b1;
                state_n = ISSUE;
            end
            ISSUE: begin
                cnt_n   = LW'(CAL_LAT - 1);
                state_n = WAIT;
            end
            WAIT: begin
                if (cnt == '0) begin
                    dout_n = cal_out;
                    ch_n   = last_grant;
                    dv_n   = 1'b1;
                    arb    = 1'b1;
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        // Final WAIT cycle re-arbitrates so conversions run back to back.
        if (arb) begin
            if (win) begin
                last_n     = gnt;
                cal_in_n   = sel;
                ack_n[gnt] = 1'b1;
                clr_n      = 1'b1;
                busy_n     = 1'b1;
                state_n    = CLEAR;
            end else begin
                busy_n  = 1'b0;
                state_n = IDLE;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            last_grant <= CW'(NCH - 1);
            cnt        <= '0;
            ack        <= '0;
            cal_clear  <= 1'b0;
            cal_enable <= 1'b0;
            cal_in     <= '0;
            dout       <= '0;
            dout_ch    <= '0;
            dout_valid <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_n;
            last_grant <= last_n;
            cnt        <= cnt_n;
            ack        <= ack_n;
            cal_clear  <= clr_n;
            cal_enable <= en_n;
            cal_in     <= cal_in_n;
            dout       <= dout_n;
            dout_ch    <= ch_n;
            dout_valid <= dv_n;
            busy       <= busy_n;
        end
    end

endmodule

// File: doc/calib_sched.md
# calib_sched

Round-robin scheduler that shares one wind-speed calibration engine (the LUT binary-search/interpolation unit) between NCH raw-sample requesters. It latches a granted sample, clears the engine's search pointers, pulses the engine enable, waits the engine's fixed latency, then returns the calibrated value tagged with its channel number. It sits between the sensor front-end channels and the single calibration datapath, so no requester ever drives that datapath directly.

## Interface
- NCH, 4: number of requesting channels (2..8).
- DW, 16: sample and calibrated-value width.
- CAL_LAT, 5: cycles from the engine enable pulse until its output is valid (≥1).
- CW, $clog2(NCH): channel index width.
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- req  in  NCH  level request per channel; held until acked.
- din  in  NCH*DW  packed raw samples, channel i at [i*DW +: DW]; valid while req[i]=1.
- ack  out  NCH  one-cycle pulse: sample of that channel accepted.
- cal_clear  out  1  one-cycle synchronous clear of engine search state.
- cal_enable  out  1  one-cycle start pulse to engine.
- cal_in  out  DW  sample presented to engine; stable for whole conversion.
- cal_out  in  DW  engine result.
- dout  out  DW  captured calibrated value.
- dout_ch  out  CW  channel the dout belongs to.
- dout_valid  out  1  one-cycle strobe for dout/dout_ch.
- busy  out  1  high from ack cycle until the last WAIT cycle.

## Operation
- All outputs registered. Reset values: ack=0, cal_clear=0, cal_enable=0, cal_in=0, dout=0, dout_ch=0, dout_valid=0, busy=0, state=IDLE, last_grant=NCH-1, wait counter=0.
- FSM states: IDLE, CLEAR, ISSUE, WAIT.
- Arbitration (evaluated in IDLE and in the final WAIT cycle): search req starting at (last_grant+1) mod NCH, wrapping; first set bit wins. On a win: last_grant<=g, cal_in<=din[g], ack[g]<=1, cal_clear<=1, busy<=1, state<=CLEAR. No req: stay/return IDLE, busy<=0.
- CLEAR (1 cycle): cal_clear=1, ack=1. Next: cal_enable<=1, state<=ISSUE.
- ISSUE (1 cycle): cal_enable=1. Next: counter<=CAL_LAT-1, state<=WAIT.
- WAIT: counter decrements each cycle; when counter==0: dout<=cal_out, dout_ch<=last_grant, dout_valid<=1, and arbitration runs in the same edge (back-to-back conversions).
- cal_in changes only on a grant; din changes after ack have no effect on the active conversion.
- A req dropped before being acked is never acked; no sample is lost for a requester that holds req.
- Reset at any time (including mid-WAIT) returns every register to its reset value immediately; the in-flight conversion is discarded, no dout_valid follows, and priority restarts at channel 0.

## Timing
- Cycle T = cycle in which ack[g] and cal_clear are high.
- cal_enable high in T+1; cal_in stable T..T+CAL_LAT+1.
- dout_valid high in T+CAL_LAT+2; dout/dout_ch hold until next dout_valid.
- With continuous requests, next ack coincides with dout_valid: conversion period CAL_LAT+2 cycles.
- From idle, req rising in cycle C (sampled at edge ending C) → ack in C+1.
- ack, cal_clear, cal_enable, dout_valid are strictly single-cycle; never two ack bits at once.

## Test plan
- Single request: CAL_LAT=5, req[2]=1, din ch2=0x1234, engine stub returns 0x00AB → ack[2] at T, cal_enable at T+1, cal_in=0x1234 T..T+6, dout_valid at T+7 with dout=0x00AB, dout_ch=2, busy low at T+7 if no other req.
- Full load: req=4'b1111 held, din ch i=0x100*i → acks in order 0,1,2,3,0 every 7 cycles; dout_ch sequence 0,1,2,3 matching cal_in 0x000,0x100,0x200,0x300.
- Rotation fairness: after grant to ch1, req=4'b1010 → next ack[3], then ack[1].
- Sample isolation: change din ch0 to 0xFFFF in T+1 after ack[0] for 0x0042 → cal_in stays 0x0042 through T+6.
- Reset mid-WAIT: assert reset at T+4 for 2 cycles → all outputs 0 asynchronously, no dout_valid; with req=4'b1001 after release → ack[0] first.
- Dropped request: req[1] pulsed for 3 cycles while busy with ch0 → ack[1] never asserted, scheduler returns to IDLE, busy=0.
